// File: rtl/glitch_test_ctrl.sv
// Exhaustive 4-input test sequencer for a combinational DUT: applies 16 vectors,
// waits a settle window, counts mismatches and multi-edge (glitchy) responses.
module glitch_test_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned GRAY_ORDER = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_tbl,
    input  logic        x_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [4:0]  glitch_cnt
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [3:0]  vec;
    logic [7:0]  settle_cnt;
    logic [1:0]  edge_cnt;
    logic        x_meta, x_s, x_prev;
    logic        settle_last;
    logic        run_abort;

    assign vec         = (GRAY_ORDER != 0) ? (idx ^ (idx >> 1)) : idx;
    assign settle_last = (settle_cnt == 8'(SETTLE_CYC - 1));
    assign busy        = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign run_abort   = busy && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = APPLY;
            APPLY:   state_nx = abort ? IDLE : SETTLE;
            SETTLE:  if (abort) state_nx = IDLE;
                     else if (settle_last) state_nx = CHECK;
            CHECK:   if (abort) state_nx = IDLE;
                     else state_nx = (idx == 4'd15) ? DONE : APPLY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done is registered out of DONE so it rises together with the final pass value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_meta     <= 1'b0;
            x_s        <= 1'b0;
            x_prev     <= 1'b0;
            idx        <= '0;
            abcd       <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            err_cnt    <= '0;
            glitch_cnt <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
        end else begin
            x_meta <= x_in;
            x_s    <= x_meta;
            x_prev <= x_s;
            done   <= 1'b0;
            if (run_abort) begin
                pass <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        idx        <= '0;
                        err_cnt    <= '0;
                        glitch_cnt <= '0;
                        pass       <= 1'b0;
                    end
                    APPLY: begin
                        abcd       <= vec;
                        settle_cnt <= '0;
                        edge_cnt   <= '0;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 8'd1;
                        if ((x_s != x_prev) && (edge_cnt != 2'd3))
                            edge_cnt <= edge_cnt + 2'd1;
                    end
                    CHECK: begin
                        if (x_s != exp_tbl[abcd]) err_cnt <= err_cnt + 5'd1;
                        if (edge_cnt >= 2'd2)     glitch_cnt <= glitch_cnt + 5'd1;
                        if (idx != 4'd15)         idx <= idx + 4'd1;
                    end
                    DONE: begin
                        done <= 1'b1;
                        pass <= (err_cnt == 5'd0) && (glitch_cnt == 5'd0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_test_ctrl.sv
// Directed bench for glitch_test_ctrl: binary-order and Gray-order instances driven
// by a behavioural a&b|c&d DUT or a forced x level with injected pulses.
module tb_glitch_test_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_b, start_g, abort_b, abort_g;
    logic [15:0] exp_b, exp_g;
    logic        x_force_en, x_force;
    logic        x_in_b, x_in_g;
    logic [3:0]  abcd_b, abcd_g;
    logic        busy_b, busy_g, done_b, done_g, pass_b, pass_g;
    logic [4:0]  err_b, err_g, glitch_b, glitch_g;

    int checks = 0;
    int errors = 0;
    int dc, dp;
    logic [3:0] gray_tbl [16];

    always #5 clk = ~clk;

    assign x_in_b = x_force_en ? x_force : ((abcd_b[3] & abcd_b[2]) | (abcd_b[1] & abcd_b[0]));
    assign x_in_g = (abcd_g[3] & abcd_g[2]) | (abcd_g[1] & abcd_g[0]);

    glitch_test_ctrl #(.SETTLE_CYC(4), .GRAY_ORDER(0)) u_bin (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .exp_tbl(exp_b),
        .x_in(x_in_b), .abcd(abcd_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .glitch_cnt(glitch_b)
    );

    glitch_test_ctrl #(.SETTLE_CYC(4), .GRAY_ORDER(1)) u_gray (
        .clk(clk), .rst_n(rst_n), .start(start_g), .abort(abort_g), .exp_tbl(exp_g),
        .x_in(x_in_g), .abcd(abcd_g), .busy(busy_g), .done(done_g), .pass(pass_g),
        .err_cnt(err_g), .glitch_cnt(glitch_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns #1 after the edge that accepts start (edge 0).
    task automatic start_run(input bit gray);
        @(negedge clk);
        if (gray) start_g = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_g = 1'b0;
        start_b = 1'b0;
    endtask

    // Runs the binary instance for 120 edges; optional x pulse inside vector gv's
    // settle window and optional abort sampled on edge abort_cyc+1.
    task automatic run_bin(input int gv, input int abort_cyc,
                           output int done_cyc, output int pulses);
        done_cyc = 0;
        pulses   = 0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            if (done_b) begin
                pulses++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (gv >= 0 && c == 6*gv + 1) x_force = 1'b0;
            if (gv >= 0 && c == 6*gv + 2) x_force = 1'b1;
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                chk("abort_busy", busy_b, 0);
                chk("abort_abcd_hold", abcd_b, abort_cyc / 6);
            end
            abort_b = (c == abort_cyc);
        end
    endtask

    initial begin
        gray_tbl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        rst_n = 1'b1; start_b = 1'b0; start_g = 1'b0; abort_b = 1'b0; abort_g = 1'b0;
        exp_b = 16'hFFFF; exp_g = 16'hF888; x_force_en = 1'b1; x_force = 1'b1;
        #2 rst_n = 1'b0;
        idle_cycles(3);
        chk("rst_abcd", abcd_b, 0);
        chk("rst_busy", busy_b, 0);
        chk("rst_done", done_b, 0);
        chk("rst_pass", pass_b, 0);
        chk("rst_err", err_b, 0);
        chk("rst_glitch", glitch_b, 0);
        rst_n = 1'b1;
        idle_cycles(3);

        // x tied high, all-ones expectation
        start_run(0);
        run_bin(-1, -1, dc, dp);
        chk("t1_done_cyc", dc, 97);
        chk("t1_done_pulses", dp, 1);
        chk("t1_pass", pass_b, 1);
        chk("t1_err", err_b, 0);
        chk("t1_glitch", glitch_b, 0);
        chk("t1_busy", busy_b, 0);

        // Gray order against the a&b|c&d model
        start_run(1);
        dc = 0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            if (c % 6 == 1 && c <= 91) chk("gray_abcd", abcd_g, gray_tbl[c / 6]);
            if (done_g && dc == 0) dc = c;
        end
        chk("gray_done_cyc", dc, 97);
        chk("gray_pass", pass_g, 1);
        chk("gray_err", err_g, 0);
        chk("gray_glitch", glitch_g, 0);

        // Binary model with bit 0 of the table wrong
        x_force_en = 1'b0;
        exp_b = 16'hF889;
        idle_cycles(3);
        start_run(0);
        run_bin(-1, -1, dc, dp);
        chk("t3_done_cyc", dc, 97);
        chk("t3_err", err_b, 1);
        chk("t3_glitch", glitch_b, 0);
        chk("t3_pass", pass_b, 0);

        // All-zero table: seven indices of the model produce 1
        exp_b = 16'h0000;
        start_run(0);
        run_bin(-1, -1, dc, dp);
        chk("t4_err", err_b, 7);
        chk("t4_pass", pass_b, 0);

        // 1-0-1 pulse inside vector 5's window
        x_force_en = 1'b1; x_force = 1'b1; exp_b = 16'hFFFF;
        idle_cycles(3);
        start_run(0);
        run_bin(5, -1, dc, dp);
        chk("t5_done_cyc", dc, 97);
        chk("t5_glitch", glitch_b, 1);
        chk("t5_err", err_b, 0);
        chk("t5_pass", pass_b, 0);

        // Abort during SETTLE of vector 7
        start_run(0);
        run_bin(-1, 44, dc, dp);
        chk("t6_done_pulses", dp, 0);
        chk("t6_pass", pass_b, 0);
        chk("t6_err", err_b, 0);
        chk("t6_busy", busy_b, 0);

        // Abort during CHECK of a mismatching vector 0 discards its increment
        x_force_en = 1'b0; exp_b = 16'hF889;
        idle_cycles(3);
        start_run(0);
        run_bin(-1, 5, dc, dp);
        chk("t7_done_pulses", dp, 0);
        chk("t7_err", err_b, 0);

        // start held high, then reset in the second run's vector 3
        x_force_en = 1'b1; x_force = 1'b1; exp_b = 16'hFFFF;
        idle_cycles(3);
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 118; c++) begin
            @(posedge clk); #1;
            if (c == 19)  chk("held_abcd_run1", abcd_b, 3);
            if (c == 96)  chk("held_busy_last", busy_b, 0);
            if (c == 97) begin
                chk("held_done", done_b, 1);
                chk("held_pass", pass_b, 1);
            end
            if (c == 98) begin
                chk("held_restart_busy", busy_b, 1);
                chk("held_restart_pass", pass_b, 0);
            end
            if (c == 117) chk("held_abcd_run2", abcd_b, 3);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_abcd", abcd_b, 0);
        chk("midrst_busy", busy_b, 0);
        chk("midrst_done", done_b, 0);
        chk("midrst_pass", pass_b, 0);
        chk("midrst_err", err_b, 0);
        chk("midrst_glitch", glitch_b, 0);
        start_b = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dp = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done_b || busy_b) dp++;
        end
        chk("post_rst_quiet", dp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_test_ctrl.md
GLITCH_TEST_CTRL -- requirements
Module: glitch_test_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 4, the settle-window length in clock cycles per vector (legal range 3..255).
REQ-002 SHALL provide parameter GRAY_ORDER, default 0, which selects the vector order: 0 = binary, 1 = reflected Gray.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one full 16-vector test run.
REQ-006 SHALL have port abort, input, 1 bit: synchronous run cancel.
REQ-007 SHALL have port exp_tbl, input, 16 bits: expected output; bit i is the expected x for index i.
REQ-008 SHALL have port x_in, input, 1 bit: output of the combinational DUT; asynchronous to clk.
REQ-009 SHALL have port abcd, output, 4 bits: DUT stimulus, with abcd[3]=a and abcd[0]=d.
REQ-010 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a completed run.
REQ-012 SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-013 SHALL have port err_cnt, output, 5 bits: count of vectors whose sampled x mismatched exp_tbl.
REQ-014 SHALL have port glitch_cnt, output, 5 bits: count of vectors with 2 or more x transitions in the settle window.

Function
REQ-015 SHALL pass x_in through a 2-flop synchronizer to form x_s; all checks use x_s only.
REQ-016 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-017 SHALL, in IDLE with start=1, clear idx, err_cnt, glitch_cnt and pass, then go to APPLY.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL, in APPLY (1 cycle), register abcd from the vector map, clear the settle counter and edge counter, then go to SETTLE.
REQ-020 SHALL map vectors as follows: GRAY_ORDER=0 gives abcd=idx; GRAY_ORDER=1 gives abcd=idx^(idx>>1).
REQ-021 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, then go to CHECK.
REQ-022 SHALL, during SETTLE, increment a 2-bit edge counter (saturating at 3) on each cycle where x_s differs from its previous-cycle value.
REQ-023 SHALL, in CHECK (1 cycle), increment err_cnt if x_s != exp_tbl[abcd].
REQ-024 SHALL, in CHECK, increment glitch_cnt if the edge count is 2 or more; both increments may occur in the same cycle.
REQ-025 SHALL, leaving CHECK, go to DONE if idx==15, else increment idx and go to APPLY.
REQ-026 SHALL, in DONE (1 cycle), assert done=1 and set pass=(err_cnt==0 && glitch_cnt==0), then go to IDLE.
REQ-027 SHALL hold pass, err_cnt and glitch_cnt in IDLE until the next accepted start.
REQ-028 SHALL drive busy=1 in APPLY, SETTLE and CHECK, and busy=0 in IDLE and DONE.
REQ-029 SHALL assert done exactly 16*(SETTLE_CYC+2)+1 cycles after the edge that accepts start (97 cycles at default).
REQ-030 SHALL never wrap err_cnt or glitch_cnt (maximum value 16 fits in 5 bits).
REQ-031 SHALL, when abort=1 in APPLY, SETTLE or CHECK, go to IDLE on the next edge; in that case done is not pulsed, pass=0, counters hold their partial values, and abcd holds.
REQ-032 SHALL give abort priority over a CHECK transition in the same cycle; that vector's increment is discarded.
REQ-033 SHALL ignore abort in IDLE and DONE.

Reset
REQ-034 SHALL, on rst_n=0, immediately force state=IDLE, idx=0, abcd=0, busy=0, done=0, pass=0, err_cnt=0, glitch_cnt=0, synchronizer flops=0 and edge counter=0.
REQ-035 SHALL, on reset asserted mid-run, abandon the run with no done pulse; operation resumes only on a new start after rst_n=1.

Verification
REQ-036 SHALL cover: x_in tied to 1, exp_tbl=16'hFFFF, start pulse -> done at cycle 97, pass=1, err_cnt=0, glitch_cnt=0.
REQ-037 SHALL cover: x_in = DUT model a&b | c&d, exp_tbl=16'hF888, GRAY_ORDER=1 -> pass=1, abcd sequence 0,1,3,2,6,7,5,4,...
REQ-038 SHALL cover: same DUT model, exp_tbl=16'hF889 -> err_cnt=1 (index 0), pass=0.
REQ-039 SHALL cover: x_in pulses 1-0 for 1 cycle each, injected inside the settle window of vector 5 -> glitch_cnt=1, err_cnt=0, pass=0.
REQ-040 SHALL cover: abort=1 during SETTLE of vector 7 -> IDLE next edge, no done pulse, busy=0, pass=0.
REQ-041 SHALL cover: start held high throughout a run -> a new run starts only after the DONE state; rst_n=0 at vector 3 -> all outputs 0 immediately.
